idli_sqi_seq_m: RTL and testbench

Per-memory SQI transaction sequencer that sits directly downstream of the core's SQI interface block, between it and one external SQI SRAM. It is instantiated twice, once for the low-nibble memory and once for the high-nibble memory. On each redirect it drives chip-select, command, 24-bit address and dummy phases, then streams data nibbles in sequential mode until the next redirect. The parent drives SCK from o_seq_sck_en and owns the pads.

---
 rtl/idli_pkg.sv | 27 ++
 rtl/idli_sqi_seq_m.sv | 141 ++++++++++++++
 tb/tb_idli_sqi_seq_m.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// ============================================================================
// idli_pkg : shared types and SQI command constants for the idli core
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package idli_pkg;

  typedef logic [3:0]  slice_t;
  typedef logic [15:0] data_t;
  typedef logic [23:0] sqi_addr_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_GAP   = 3'd1,
    SEQ_CMD   = 3'd2,
    SEQ_ADDR  = 3'd3,
    SEQ_DUMMY = 3'd4,
    SEQ_DATA  = 3'd5
  } seq_state_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

endpackage

`default_nettype wire

// File: rtl/idli_sqi_seq_m.sv
// ============================================================================
// idli_sqi_seq_m : per-memory SQI sequencer (CS/CMD/ADDR/DUMMY, then streaming)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module idli_sqi_seq_m
  import idli_pkg::*;
#(
  parameter int DUMMY_CYC = 2,
  parameter int ADDR_NIB  = 6
) (
  input  logic       i_sqi_gck,
  input  logic       i_sqi_rst_n,
  input  logic       i_seq_redirect,
  input  logic       i_seq_wr,
  input  logic [15:0] i_seq_addr,
  input  logic       i_seq_hold,
  input  logic [3:0] i_seq_slice,
  output logic [3:0] o_seq_slice,
  output logic       o_seq_slice_vld,
  output logic       o_seq_wr_rdy,
  output logic       o_seq_cs,
  output logic       o_seq_sck_en,
  output logic [3:0] o_seq_sio,
  output logic       o_seq_sio_oe,
  input  logic [3:0] i_seq_sio
);

  localparam logic [2:0] ADDR_LAST  = 3'(ADDR_NIB - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYC - 1);

  seq_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_q;
  sqi_addr_t  addr_q;

  logic [7:0] cmd;
  logic [2:0] nib_sel;
  logic [3:0] addr_nib;

  assign cmd      = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;
  assign nib_sel  = ADDR_LAST - cnt_q;
  assign addr_nib = addr_q[{nib_sel, 2'b00} +: 4];

  // Read data is a straight passthrough; o_seq_slice_vld qualifies it.
  assign o_seq_slice = i_seq_sio;

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (i_seq_redirect) begin
        wr_q   <= i_seq_wr;
        addr_q <= {8'h00, i_seq_addr};
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    o_seq_cs        = 1'b0;
    o_seq_sck_en    = 1'b0;
    o_seq_sio       = 4'h0;
    o_seq_sio_oe    = 1'b0;
    o_seq_slice_vld = 1'b0;
    o_seq_wr_rdy    = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        o_seq_cs = 1'b1;
      end
      SEQ_GAP: begin
        o_seq_cs = 1'b1;
        state_d  = SEQ_CMD;
        cnt_d    = 3'd0;
      end
      SEQ_CMD: begin
        o_seq_sck_en = 1'b1;
        o_seq_sio_oe = 1'b1;
        o_seq_sio    = cnt_q[0] ? cmd[3:0] : cmd[7:4];
        if (cnt_q == 3'd1) begin
          state_d = SEQ_ADDR;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SEQ_ADDR: begin
        o_seq_sck_en = 1'b1;
        o_seq_sio_oe = 1'b1;
        o_seq_sio    = addr_nib;
        if (cnt_q == ADDR_LAST) begin
          state_d = wr_q ? SEQ_DATA : SEQ_DUMMY;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SEQ_DUMMY: begin
        o_seq_sck_en = 1'b1;
        if (cnt_q == DUMMY_LAST) begin
          state_d = SEQ_DATA;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SEQ_DATA: begin
        // Memory auto-increments, so hold simply withholds the SCK pulse.
        o_seq_sck_en = !i_seq_hold;
        if (wr_q) begin
          o_seq_sio_oe = 1'b1;
          o_seq_sio    = i_seq_slice;
          o_seq_wr_rdy = !i_seq_hold;
        end else begin
          o_seq_slice_vld = !i_seq_hold;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // A live transaction needs one CS-high cycle before the new command.
    if (i_seq_redirect) begin
      state_d = (state_q == SEQ_IDLE) ? SEQ_CMD : SEQ_GAP;
      cnt_d   = 3'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_seq_m.sv
// ============================================================================
// tb_idli_sqi_seq_m : scoreboard bench with an SQI SRAM model for the sequencer
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_idli_sqi_seq_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, wr, hold;
  logic [15:0] addr;
  logic [3:0]  slice_in, slice_out, sio, sio_in;
  logic        vld, rdy, cs, sck_en, oe;

  always #5 clk = ~clk;

  idli_sqi_seq_m dut (
    .i_sqi_gck       (clk),
    .i_sqi_rst_n     (rst_n),
    .i_seq_redirect  (redirect),
    .i_seq_wr        (wr),
    .i_seq_addr      (addr),
    .i_seq_hold      (hold),
    .i_seq_slice     (slice_in),
    .o_seq_slice     (slice_out),
    .o_seq_slice_vld (vld),
    .o_seq_wr_rdy    (rdy),
    .o_seq_cs        (cs),
    .o_seq_sck_en    (sck_en),
    .o_seq_sio       (sio),
    .o_seq_sio_oe    (oe),
    .i_seq_sio       (sio_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- SQI SRAM model: byte array, nibbles MSB first ----------
  logic [7:0]  mem [0:131071];
  bit          mem_init = 1'b0;
  int          sn = 0;
  logic [7:0]  scmd = 8'h00;
  logic [23:0] saddr = 24'h0;
  int          rd_k;
  logic [16:0] ridx;
  logic [7:0]  rbyte;

  always @(posedge clk) begin
    int          k;
    logic [16:0] widx;
    if (!mem_init) begin
      for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
      mem_init = 1'b1;
    end
    if (cs) begin
      sn <= 0;
    end else if (sck_en) begin
      if (sn < 2) scmd <= {scmd[3:0], sio};
      else if (sn < 8) saddr <= {saddr[19:0], sio};
      else if (scmd == 8'h02) begin
        k    = sn - 8;
        widx = saddr[16:0] + 17'(k / 2);
        if (k % 2 == 0) mem[widx][7:4] = sio;
        else            mem[widx][3:0] = sio;
      end
      sn <= sn + 1;
    end
  end

  assign rd_k   = sn - 10;
  assign ridx   = saddr[16:0] + 17'(rd_k / 2);
  assign rbyte  = mem[ridx];
  assign sio_in = (!cs && scmd == 8'h03 && sn >= 10) ? (rd_k[0] ? rbyte[3:0] : rbyte[7:4]) : 4'h0;

  // ---------------- scoreboard state --------------------------------------
  logic [3:0] bus_exp[$];
  logic [3:0] rd_exp[$];
  logic [3:0] wq[$];
  logic [3:0] wpat[$];
  int         lat_q[$];

  int cyc = 0;
  int rel = 100;
  int rd_cnt = 0;
  int cur_n = 0;
  bit cur_wr = 1'b0;
  int mode = 0;
  bit rdy_seen = 1'b0;
  int cs_cur = 0;
  int cs_run = 0;
  bit armed = 1'b0;
  int lat_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_idle", 32'({cs, sck_en, oe, vld, rdy, sio}), 32'h100);
      armed    = 1'b0;
      rdy_seen = 1'b0;
      cs_cur   = 0;
    end else begin
      if (cs) begin
        chk("cs_quiet", 32'({sck_en, oe, vld, rdy}), 32'h0);
        cs_cur++;
      end else begin
        if (cs_cur > 0) cs_run = cs_cur;
        cs_cur = 0;
      end
      if (hold) chk("hold_stall", 32'({vld, rdy}), 32'h0);
      if (sck_en && oe) begin
        if (bus_exp.size() == 0) fail("bus_extra", 32'(sio), -1);
        else chk("bus_nibble", 32'(sio), 32'(bus_exp.pop_front()));
      end
      if (vld) begin
        if (rd_exp.size() == 0) fail("rd_extra", 32'(slice_out), -1);
        else chk("rd_nibble", 32'(slice_out), 32'(rd_exp.pop_front()));
        rd_cnt++;
      end
      rdy_seen = rdy;
      if (armed && (vld || rdy)) begin
        armed = 1'b0;
        if (lat_q.size() == 0) fail("latency_extra", cyc - lat_start, -1);
        else chk("latency", 32'(cyc - lat_start), 32'(lat_q.pop_front()));
      end
      if (redirect) begin
        armed     = 1'b1;
        lat_start = cyc;
      end
    end
  end

  // ---------------- driver -------------------------------------------------
  task automatic step();
    bit done;
    @(posedge clk);
    #1;
    if (rdy_seen && wq.size() > 0) void'(wq.pop_front());
    rel++;
    redirect = 1'b0;
    done     = cur_wr ? (wq.size() == 0) : (rd_cnt >= cur_n);
    // Hold before DATA must be ignored, so toggle it freely there.
    hold     = done || (rel < 9 && $urandom_range(0, 1) == 0);
    if (mode == 1 && (rel == 12 || rel == 13)) hold = 1'b1;
    if (mode == 2 && rel > 13 && $urandom_range(0, 3) == 0) hold = 1'b1;
    slice_in = (wq.size() > 0) ? wq[0] : 4'($urandom);
    if (mode == 1 && (rel == 12 || rel == 13)) begin
      @(negedge clk);
      chk("hold_sck", 32'({sck_en, vld}), 32'h0);
    end
  endtask

  task automatic push_txn(input bit w, input logic [15:0] a, input int n, input bit from_idle);
    logic [23:0] a24;
    logic [7:0]  b;
    logic [3:0]  nib;
    a24 = {8'h00, a};
    bus_exp.push_back(4'h0);
    bus_exp.push_back(w ? 4'h2 : 4'h3);
    for (int i = 0; i < 6; i++) bus_exp.push_back(a24[23 - 4*i -: 4]);
    if (w) begin
      for (int i = 0; i < n; i++) begin
        nib = (wpat.size() > 0) ? wpat.pop_front() : 4'($urandom);
        wq.push_back(nib);
        bus_exp.push_back(nib);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        b = mem[32'(a) + k / 2];
        rd_exp.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
      end
    end
    lat_q.push_back((w ? 9 : 11) + (from_idle ? 0 : 1));
    cur_wr = w;
    cur_n  = n;
    rd_cnt = 0;
  endtask

  task automatic issue(input bit w, input logic [15:0] a, input int n, input bit from_idle);
    step();
    push_txn(w, a, n, from_idle);
    redirect = 1'b1;
    wr       = w;
    addr     = a;
    hold     = 1'b1;
    rel      = 0;
  endtask

  task automatic flush();
    bus_exp.delete();
    rd_exp.delete();
    wq.delete();
    lat_q.delete();
    cur_wr = 1'b0;
    cur_n  = 0;
    rd_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus_exp.size() == 0 && rd_exp.size() == 0 && wq.size() == 0 && lat_q.size() == 0) break;
      step();
    end
    if (bus_exp.size() != 0 || rd_exp.size() != 0 || wq.size() != 0 || lat_q.size() != 0) begin
      fail("timeout_pending", bus_exp.size() + rd_exp.size() + wq.size() + lat_q.size(), 0);
      flush();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    bit          rw;
    rst_n    = 1'b0;
    redirect = 1'b0;
    wr       = 1'b0;
    addr     = 16'h0;
    hold     = 1'b0;
    slice_in = 4'h0;

    repeat (5) step();
    rst_n = 1'b1;
    step();

    // Read from IDLE with a two-cycle hold inside DATA.
    mode = 1;
    issue(1'b0, 16'h1234, 8, 1'b1);
    wait_done(200);

    // Write from DATA, then read it back.
    mode = 0;
    wpat.push_back(4'h5);
    wpat.push_back(4'h6);
    wpat.push_back(4'h7);
    issue(1'b1, 16'hBEEF, 3, 1'b0);
    wait_done(200);
    step();
    chk("mem_beef", 32'(mem[32'hBEEF]), 32'h56);
    chk("mem_bef0_hi", 32'(mem[32'hBEF0][7:4]), 32'h7);
    chk("gap_cs_run", 32'(cs_run), 32'd1);
    issue(1'b0, 16'hBEEF, 3, 1'b0);
    wait_done(200);

    // Back-to-back redirect: the second, landing in GAP, wins.
    step();
    push_txn(1'b0, 16'h0020, 4, 1'b0);
    redirect = 1'b1; wr = 1'b0; addr = 16'h0010; hold = 1'b1; rel = 0;
    step();
    redirect = 1'b1; wr = 1'b0; addr = 16'h0020; hold = 1'b1; rel = 0;
    wait_done(200);
    chk("double_gap_cs_run", 32'(cs_run), 32'd2);

    // Randomized traffic with random holds in DATA.
    mode = 2;
    for (int t = 0; t < 10; t++) begin
      rw = 1'($urandom);
      ra = 16'($urandom);
      issue(rw, ra, int'($urandom_range(1, 9)), 1'b0);
      wait_done(400);
    end

    // Async reset in the middle of ADDR abandons the transaction.
    mode = 0;
    issue(1'b0, 16'h0ABC, 4, 1'b0);
    while (rel < 8) step();
    #1 rst_n = 1'b0;
    #1 chk("async_cs", 32'({cs, sck_en, oe}), 32'h4);
    flush();
    repeat (3) step();
    rst_n = 1'b1;
    ra = 16'($urandom);
    issue(1'b1, ra, 4, 1'b1);
    wait_done(200);
    issue(1'b0, ra, 4, 1'b0);
    wait_done(200);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
